pipe_hazard_ctrl: RTL and testbench

Pipeline hazard/sequencing controller for the 16-bit 5-stage datapath. It drives the IF/ID buffer's flush and nop_in controls, the PC write enable, and the ID/EX bubble insert. It resolves load-use stalls, taken-branch flushes, memory-busy freezes and HLT, and arbitrates between them by fixed priority.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_haz_detect.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional HAZ_PERF_CNT_EN adds stall/flush performance counters (see top).
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int R0_IDX     = 0;
  localparam int CNT_W      = 3;
  localparam int PERF_W     = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/control bundle between the pipeline datapath (master) and the hazard controller (slave).
// Perf counter outputs exist only when HAZ_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = pipe_hazard_ctrl_pkg::REG_ADDR_W
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  halt_req;
  logic                  pc_write_en;
  logic                  if_id_flush;
  logic                  if_id_nop;
  logic                  id_ex_bubble;
  logic                  pipe_hold;
  logic                  halted;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0]           stall_cnt;
  logic [15:0]           flush_cnt;
`endif

  modport master (
    output id_rs1, id_rs1_used, id_rs2, id_rs2_used, ex_rd, ex_mem_read,
    output branch_taken, mem_busy, halt_req,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    input  pc_write_en, if_id_flush, if_id_nop, id_ex_bubble, pipe_hold, halted
  );

  modport slave (
    input  id_rs1, id_rs1_used, id_rs2, id_rs2_used, ex_rd, ex_mem_read,
    input  branch_taken, mem_busy, halt_req,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    output pc_write_en, if_id_flush, if_id_nop, id_ex_bubble, pipe_hold, halted
  );

endinterface

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds an ID source operand.
module haz_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);
  import pipe_hazard_ctrl_pkg::*;

  logic [1:0][REG_ADDR_W-1:0] src_addr;
  logic [1:0]                 src_used;
  logic [1:0]                 src_hit;

  assign src_addr = {rs2, rs1};
  assign src_used = {rs2_used, rs1_used};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_addr[gi] == ex_rd);
    end
  endgenerate

  // R0 is hardwired zero, so a load targeting it can never create a dependency
  assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(R0_IDX)) && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: fixed priority mem_busy > branch > load-use > halt.
// Define HAZ_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W   = pipe_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_hazard_ctrl_if.slave        hz
);
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LU_INIT    = CNT_W'(LOAD_LAT - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             load_use;

  logic pc_write_en_c, if_id_flush_c, if_id_nop_c, id_ex_bubble_c, pipe_hold_c, halted_c;

  haz_detect #(.REG_ADDR_W(REG_ADDR_W)) u_haz_detect (
    .rs1         (hz.id_rs1),
    .rs1_used    (hz.id_rs1_used),
    .rs2         (hz.id_rs2),
    .rs2_used    (hz.id_rs2_used),
    .ex_rd       (hz.ex_rd),
    .ex_mem_read (hz.ex_mem_read),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    // A memory freeze holds the sequencer exactly where it is; only HALT ignores it
    if (!(hz.mem_busy && state_reg != HALT)) begin
      case (state_reg)
        RUN: begin
          if (hz.branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              cnt_next   = FLUSH_INIT;
            end
          end else if (load_use) begin
            if (LOAD_LAT > 1) begin
              state_next = LU_STALL;
              cnt_next   = LU_INIT;
            end
          end else if (hz.halt_req) begin
            state_next = HALT;
          end
        end
        FLUSH, LU_STALL: begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) state_next = RUN;
        end
        HALT:    state_next = HALT;
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    pc_write_en_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    if_id_nop_c    = 1'b0;
    id_ex_bubble_c = 1'b0;
    pipe_hold_c    = 1'b0;
    halted_c       = 1'b0;
    if (!rst) begin
      pc_write_en_c = 1'b0;
    end else if (state_reg == HALT) begin
      if_id_nop_c    = 1'b1;
      id_ex_bubble_c = 1'b1;
      halted_c       = 1'b1;
    end else if (hz.mem_busy) begin
      // Freeze: no bubble injected since ID/EX itself is held
      pipe_hold_c   = 1'b1;
      if_id_nop_c   = 1'b1;
      if_id_flush_c = (state_reg == FLUSH);
    end else begin
      case (state_reg)
        RUN: begin
          pc_write_en_c = 1'b1;
          if (hz.branch_taken) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
          end else if (load_use || hz.halt_req) begin
            pc_write_en_c  = 1'b0;
            if_id_nop_c    = 1'b1;
            id_ex_bubble_c = 1'b1;
          end
        end
        FLUSH: begin
          pc_write_en_c  = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end
        LU_STALL: begin
          if_id_nop_c    = 1'b1;
          id_ex_bubble_c = 1'b1;
        end
        default: pc_write_en_c = 1'b0;
      endcase
    end
  end

  assign hz.pc_write_en  = pc_write_en_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.if_id_nop    = if_id_nop_c;
  assign hz.id_ex_bubble = id_ex_bubble_c;
  assign hz.pipe_hold    = pipe_hold_c;
  assign hz.halted       = halted_c;

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic              stall_inc, flush_inc;

  assign stall_inc = !pc_write_en_c && (state_reg == RUN || state_reg == LU_STALL);
  // A branch is accepted only in RUN and only when not frozen by memory
  assign flush_inc = (state_reg == RUN) && hz.branch_taken && !hz.mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && flush_cnt_reg != '1) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_reg;
  assign hz.flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with LOAD_LAT=2, FLUSH_CYCLES=2.
// Perf counter checks are compiled in only when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int LL = 2;
  localparam int FC = 2;

  // {pc_write_en, if_id_flush, if_id_nop, id_ex_bubble, pipe_hold, halted}
  localparam logic [5:0] O_RST   = 6'b000000;
  localparam logic [5:0] O_RUN   = 6'b100000;
  localparam logic [5:0] O_STALL = 6'b001100;
  localparam logic [5:0] O_FLUSH = 6'b110100;
  localparam logic [5:0] O_BUSY  = 6'b001010;
  localparam logic [5:0] O_BUSYF = 6'b011010;
  localparam logic [5:0] O_HALT  = 6'b001101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W)) hz ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W  (REG_ADDR_W),
    .LOAD_LAT    (LL),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %-12s got=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %-12s value=%0h", tag, obs);
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    #1;
    check_val(tag, {26'd0, hz.pc_write_en, hz.if_id_flush, hz.if_id_nop,
                    hz.id_ex_bubble, hz.pipe_hold, hz.halted}, {26'd0, exp});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // lu=1 presents a load in EX writing r3 while ID reads r3 via rs1
  task automatic drive(input logic br, input logic mb, input logic hr, input logic lu);
    hz.branch_taken = br;
    hz.mem_busy     = mb;
    hz.halt_req     = hr;
    hz.ex_mem_read  = lu;
    hz.ex_rd        = lu ? REG_ADDR_W'(3) : '0;
    hz.id_rs1       = lu ? REG_ADDR_W'(3) : '0;
    hz.id_rs1_used  = lu;
    hz.id_rs2       = '0;
    hz.id_rs2_used  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_hold0", O_RST);
    next_cyc(); chk("rst_hold1", O_RST);
    next_cyc(); chk("rst_hold2", O_RST);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    chk("run_first", O_RUN);

    // load-use via rs1, two stall cycles
    next_cyc(); drive(0, 0, 0, 1); chk("lu_c1", O_STALL);
    next_cyc(); chk("lu_c2", O_STALL);
    next_cyc(); drive(0, 0, 0, 0); chk("lu_exit", O_RUN);

    // load to r0 never hazards
    next_cyc(); drive(0, 0, 0, 0);
    hz.ex_mem_read = 1'b1; hz.id_rs1_used = 1'b1;
    chk("lu_r0", O_RUN);
    next_cyc(); drive(0, 0, 0, 0); chk("lu_r0_next", O_RUN);

    // rs2 match only counts when rs2 is used
    next_cyc(); drive(0, 0, 0, 0);
    hz.ex_mem_read = 1'b1; hz.ex_rd = REG_ADDR_W'(5);
    hz.id_rs1 = REG_ADDR_W'(5); hz.id_rs2 = REG_ADDR_W'(5);
    chk("rs_unused", O_RUN);
    hz.id_rs2_used = 1'b1;
    chk("rs2_c1", O_STALL);
    next_cyc(); drive(0, 0, 0, 0); chk("rs2_c2", O_STALL);
    next_cyc(); chk("rs2_exit", O_RUN);

    // taken branch, load-use in second flush cycle ignored
    next_cyc(); drive(1, 0, 0, 0); chk("br_c1", O_FLUSH);
    next_cyc(); drive(0, 0, 0, 1); chk("br_c2_lu", O_FLUSH);
    next_cyc(); drive(0, 0, 0, 0); chk("br_exit", O_RUN);

    // branch and load-use together: flush wins
    next_cyc(); drive(1, 0, 0, 1); chk("brlu_c1", O_FLUSH);
    next_cyc(); drive(0, 0, 0, 0); chk("brlu_c2", O_FLUSH);
    next_cyc(); chk("brlu_exit", O_RUN);

    // mem_busy freezes LU_STALL with cnt=1
    next_cyc(); drive(0, 0, 0, 1); chk("mb_lu", O_STALL);
    next_cyc(); drive(0, 1, 0, 0); chk("mb_busy1", O_BUSY);
    next_cyc(); chk("mb_busy2", O_BUSY);
    next_cyc(); chk("mb_busy3", O_BUSY);
    next_cyc(); drive(0, 0, 0, 0); chk("mb_rel", O_STALL);
    next_cyc(); chk("mb_exit", O_RUN);

    // mem_busy during FLUSH keeps flush asserted
    next_cyc(); drive(1, 0, 0, 0); chk("bf_c1", O_FLUSH);
    next_cyc(); drive(0, 1, 0, 0); chk("bf_busy", O_BUSYF);
    next_cyc(); drive(0, 0, 0, 0); chk("bf_rel", O_FLUSH);
    next_cyc(); chk("bf_exit", O_RUN);

    // mem_busy beats branch; branch not accepted
    next_cyc(); drive(1, 1, 0, 0); chk("bb_busy", O_BUSY);
    next_cyc(); drive(0, 0, 0, 0); chk("bb_next", O_RUN);

    // halt is sticky until reset
    next_cyc(); drive(0, 0, 1, 0); chk("hlt_req", O_STALL);
    next_cyc(); drive(0, 0, 0, 0); chk("hlt1", O_HALT);
    next_cyc(); drive(1, 1, 0, 1); chk("hlt2", O_HALT);
    next_cyc(); drive(0, 0, 1, 0); chk("hlt3", O_HALT);
`ifdef HAZ_PERF_CNT_EN
    check_val("stall_cnt", {16'd0, hz.stall_cnt}, 32'd11);
    check_val("flush_cnt", {16'd0, hz.flush_cnt}, 32'd3);
`endif
    next_cyc(); drive(0, 0, 0, 0); rst = 1'b0; chk("hlt_rst", O_RST);
    next_cyc(); rst = 1'b1; chk("hlt_run", O_RUN);
`ifdef HAZ_PERF_CNT_EN
    check_val("stall_clr", {16'd0, hz.stall_cnt}, 32'd0);
    check_val("flush_clr", {16'd0, hz.flush_cnt}, 32'd0);
`endif

    // reset aborts a stall and a flush
    next_cyc(); drive(0, 0, 0, 1); chk("ab_lu", O_STALL);
    next_cyc(); drive(0, 0, 0, 0); rst = 1'b0; chk("ab_lu_rst", O_RST);
    next_cyc(); rst = 1'b1; chk("ab_lu_run", O_RUN);
    next_cyc(); drive(1, 0, 0, 0); chk("ab_br", O_FLUSH);
    next_cyc(); drive(0, 0, 0, 0); rst = 1'b0; chk("ab_br_rst", O_RST);
    next_cyc(); rst = 1'b1; chk("ab_br_run", O_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
